video_timing_gen: RTL and testbench

- Parametrised raster timing generator for the emu top.
- Produces pixel enable, sync, blank, DE and raster counters for the core video path and VGA_* outputs.
- Generalises the fixed NTSC/PAL timing: configurable geometry, pixel divider and sync polarity, mode switching only at frame boundaries, and an enable/freeze input.

---
 rtl/video_timing_gen.sv | 244 ++++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// A pixel-enable divider drives horizontal/vertical counters. Every decoded
// output is registered from the counter values that will be visible in the
// same cycle, so hcount/vcount and their blank/sync/DE flags always line up.
// The NTSC/PAL geometry switches only when the raster wraps to a new frame.

module video_timing_gen #(
  parameter int CE_DIV   = 2,
  parameter int HW       = 11,
  parameter int VW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 64,
  parameter int H_TOTAL  = 800,
  parameter int V_ACT_N  = 240,
  parameter int V_TOT_N  = 262,
  parameter int V_ACT_P  = 288,
  parameter int V_TOT_P  = 312,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 3,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          enable,
  input  logic          pal,
  output logic          ce_pix,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic          pal_active,
  output logic [7:0]    frame_cnt
);

  // ---------------------------------------------------------------------
  // Parameter guards: bad geometry must stop elaboration.
  // ---------------------------------------------------------------------
  if (CE_DIV < 1) begin : g_bad_div
    $error("video_timing_gen: CE_DIV must be at least 1");
  end
  if (H_TOTAL < 1 || H_TOTAL > (1 << HW)) begin : g_bad_hw
    $error("video_timing_gen: HW cannot hold H_TOTAL-1");
  end
  if (V_TOT_N < 1 || V_TOT_P < 1 || V_TOT_N > (1 << VW) || V_TOT_P > (1 << VW)) begin : g_bad_vw
    $error("video_timing_gen: VW cannot hold the larger vertical total minus one");
  end
  if (H_ACTIVE < 0 || H_FP < 0 || H_SYNC < 1 || H_ACTIVE + H_FP + H_SYNC > H_TOTAL) begin : g_bad_h
    $error("video_timing_gen: horizontal sync window lies outside H_TOTAL");
  end
  if (V_ACT_N < 0 || V_FP < 0 || V_SYNC < 1 || V_ACT_N + V_FP + V_SYNC > V_TOT_N) begin : g_bad_vn
    $error("video_timing_gen: NTSC vertical sync window lies outside V_TOT_N");
  end
  if (V_ACT_P < 0 || V_ACT_P + V_FP + V_SYNC > V_TOT_P) begin : g_bad_vp
    $error("video_timing_gen: PAL vertical sync window lies outside V_TOT_P");
  end

  // ---------------------------------------------------------------------
  // Derived constants. Window bounds carry one extra bit so that an end
  // value equal to the total (e.g. sync running up to the last pixel)
  // never truncates.
  // ---------------------------------------------------------------------
  localparam int DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VN_LAST  = VW'(V_TOT_N - 1);
  localparam logic [VW-1:0] VP_LAST  = VW'(V_TOT_P - 1);

  localparam logic [HW:0] H_ACT_X  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_BEG_X = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END_X = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW:0] VA_N_X     = (VW+1)'(V_ACT_N);
  localparam logic [VW:0] VS_BEG_N_X = (VW+1)'(V_ACT_N + V_FP);
  localparam logic [VW:0] VS_END_N_X = (VW+1)'(V_ACT_N + V_FP + V_SYNC);
  localparam logic [VW:0] VA_P_X     = (VW+1)'(V_ACT_P);
  localparam logic [VW:0] VS_BEG_P_X = (VW+1)'(V_ACT_P + V_FP);
  localparam logic [VW:0] VS_END_P_X = (VW+1)'(V_ACT_P + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ON = (VS_POL != 0) ? 1'b1 : 1'b0;

  // ---------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------
  logic [DW-1:0] div_r,        div_nxt_s;
  logic          ce_r,         ce_nxt_s;
  logic [HW-1:0] hcount_r,     hcount_nxt_s;
  logic [VW-1:0] vcount_r,     vcount_nxt_s;
  logic          pal_active_r, pal_nxt_s;
  logic [7:0]    frame_cnt_r,  frame_cnt_nxt_s;

  logic hblank_r,      hblank_nxt_s;
  logic vblank_r,      vblank_nxt_s;
  logic hsync_r,       hsync_nxt_s;
  logic vsync_r,       vsync_nxt_s;
  logic de_r,          de_nxt_s;
  logic line_start_r,  line_start_nxt_s;
  logic frame_start_r, frame_start_nxt_s;

  logic          h_last_s;
  logic          v_last_s;
  logic [HW:0]   h_ext_s;
  logic [VW:0]   v_ext_s;
  logic [VW:0]   v_act_s;
  logic [VW:0]   vs_beg_s;
  logic [VW:0]   vs_end_s;

  // Pixel divider: counts only while enabled; the pulse is raised for the
  // cycle after div reaches its last value, and is dropped while frozen.
  always_comb begin
    div_nxt_s = div_r;
    ce_nxt_s  = 1'b0;
    if (enable) begin
      if (div_r == DIV_LAST) begin
        div_nxt_s = {DW{1'b0}};
        ce_nxt_s  = 1'b1;
      end else begin
        div_nxt_s = div_r + DW'(1'b1);
        ce_nxt_s  = 1'b0;
      end
    end else begin
      div_nxt_s = div_r;
      ce_nxt_s  = 1'b0;
    end
  end

  // Raster advance: a pixel-enable cycle always completes (even if enable
  // has just dropped), moving to the next position at its closing edge.
  // The mode and frame counter change only when both counters wrap.
  always_comb begin
    h_last_s        = (hcount_r == H_LAST);
    v_last_s        = pal_active_r ? (vcount_r == VP_LAST) : (vcount_r == VN_LAST);
    hcount_nxt_s    = hcount_r;
    vcount_nxt_s    = vcount_r;
    pal_nxt_s       = pal_active_r;
    frame_cnt_nxt_s = frame_cnt_r;
    if (ce_r) begin
      if (h_last_s) begin
        hcount_nxt_s = {HW{1'b0}};
        if (v_last_s) begin
          vcount_nxt_s    = {VW{1'b0}};
          pal_nxt_s       = pal;
          frame_cnt_nxt_s = frame_cnt_r + 8'd1;
        end else begin
          vcount_nxt_s = vcount_r + VW'(1'b1);
        end
      end else begin
        hcount_nxt_s = hcount_r + HW'(1'b1);
      end
    end else begin
      hcount_nxt_s = hcount_r;
    end
  end

  // Decode from the next raster position so flags align with the counters.
  // Vertical windows follow the mode that will be in effect for that line.
  always_comb begin
    h_ext_s = {1'b0, hcount_nxt_s};
    v_ext_s = {1'b0, vcount_nxt_s};
    if (pal_nxt_s) begin
      v_act_s  = VA_P_X;
      vs_beg_s = VS_BEG_P_X;
      vs_end_s = VS_END_P_X;
    end else begin
      v_act_s  = VA_N_X;
      vs_beg_s = VS_BEG_N_X;
      vs_end_s = VS_END_N_X;
    end

    hblank_nxt_s = (h_ext_s >= H_ACT_X);
    vblank_nxt_s = (v_ext_s >= v_act_s);

    if ((h_ext_s >= HS_BEG_X) && (h_ext_s < HS_END_X)) begin
      hsync_nxt_s = HS_ON;
    end else begin
      hsync_nxt_s = ~HS_ON;
    end

    if ((v_ext_s >= vs_beg_s) && (v_ext_s < vs_end_s)) begin
      vsync_nxt_s = VS_ON;
    end else begin
      vsync_nxt_s = ~VS_ON;
    end

    de_nxt_s          = ~(hblank_nxt_s | vblank_nxt_s);
    line_start_nxt_s  = ce_nxt_s && (hcount_nxt_s == {HW{1'b0}});
    frame_start_nxt_s = line_start_nxt_s && (vcount_nxt_s == {VW{1'b0}});
  end

  // State register: reset puts the raster at the top-left with no pulses.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      div_r         <= {DW{1'b0}};
      ce_r          <= 1'b0;
      hcount_r      <= {HW{1'b0}};
      vcount_r      <= {VW{1'b0}};
      pal_active_r  <= 1'b0;
      frame_cnt_r   <= 8'd0;
      hblank_r      <= 1'b0;
      vblank_r      <= 1'b0;
      hsync_r       <= ~HS_ON;
      vsync_r       <= ~VS_ON;
      de_r          <= 1'b1;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      div_r         <= div_nxt_s;
      ce_r          <= ce_nxt_s;
      hcount_r      <= hcount_nxt_s;
      vcount_r      <= vcount_nxt_s;
      pal_active_r  <= pal_nxt_s;
      frame_cnt_r   <= frame_cnt_nxt_s;
      hblank_r      <= hblank_nxt_s;
      vblank_r      <= vblank_nxt_s;
      hsync_r       <= hsync_nxt_s;
      vsync_r       <= vsync_nxt_s;
      de_r          <= de_nxt_s;
      line_start_r  <= line_start_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  assign ce_pix      = ce_r;
  assign hcount      = hcount_r;
  assign vcount      = vcount_r;
  assign hblank      = hblank_r;
  assign vblank      = vblank_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign de          = de_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign pal_active  = pal_active_r;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (full default geometry, a
// small CE_DIV=2 geometry, and a tiny CE_DIV=1 active-high-sync geometry)
// share clock and inputs. A position/ce model is compared every cycle, and
// directed checks pin literal positions, periods and latencies.

module tb_video_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic pal = 1'b0;

  always #5 clk = ~clk;

  logic        ce [3];
  logic [10:0] hc [3];
  logic [9:0]  vc [3];
  logic        hb [3];
  logic        vb [3];
  logic        hs [3];
  logic        vs [3];
  logic        de [3];
  logic        ls [3];
  logic        fs [3];
  logic        pa [3];
  logic [7:0]  fc [3];

  // geometry of each instance
  int c_div [3] = '{2, 2, 1};
  int c_ha  [3] = '{640, 16, 4};
  int c_hfp [3] = '{16, 2, 1};
  int c_hsy [3] = '{64, 4, 1};
  int c_ht  [3] = '{800, 24, 8};
  int c_van [3] = '{240, 10, 3};
  int c_vtn [3] = '{262, 16, 6};
  int c_vap [3] = '{288, 12, 4};
  int c_vtp [3] = '{312, 20, 7};
  int c_vfp [3] = '{3, 1, 1};
  int c_vsy [3] = '{3, 2, 1};
  int c_hpl [3] = '{0, 0, 1};
  int c_vpl [3] = '{0, 0, 1};

  video_timing_gen dut0 (
    .clk_sys(clk), .reset(reset), .enable(enable), .pal(pal),
    .ce_pix(ce[0]), .hcount(hc[0]), .vcount(vc[0]), .hblank(hb[0]), .vblank(vb[0]),
    .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .line_start(ls[0]), .frame_start(fs[0]),
    .pal_active(pa[0]), .frame_cnt(fc[0]));

  video_timing_gen #(
    .CE_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_TOTAL(24),
    .V_ACT_N(10), .V_TOT_N(16), .V_ACT_P(12), .V_TOT_P(20), .V_FP(1), .V_SYNC(2),
    .HS_POL(0), .VS_POL(0)
  ) dut1 (
    .clk_sys(clk), .reset(reset), .enable(enable), .pal(pal),
    .ce_pix(ce[1]), .hcount(hc[1]), .vcount(vc[1]), .hblank(hb[1]), .vblank(vb[1]),
    .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .line_start(ls[1]), .frame_start(fs[1]),
    .pal_active(pa[1]), .frame_cnt(fc[1]));

  video_timing_gen #(
    .CE_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_TOTAL(8),
    .V_ACT_N(3), .V_TOT_N(6), .V_ACT_P(4), .V_TOT_P(7), .V_FP(1), .V_SYNC(1),
    .HS_POL(1), .VS_POL(1)
  ) dut2 (
    .clk_sys(clk), .reset(reset), .enable(enable), .pal(pal),
    .ce_pix(ce[2]), .hcount(hc[2]), .vcount(vc[2]), .hblank(hb[2]), .vblank(vb[2]),
    .hsync(hs[2]), .vsync(vs[2]), .de(de[2]), .line_start(ls[2]), .frame_start(fs[2]),
    .pal_active(pa[2]), .frame_cnt(fc[2]));

  // ------------------------------------------------------------------
  // Behavioural model: raster position, enabled-cycle count, mode, frames
  // ------------------------------------------------------------------
  typedef struct packed {
    int   h;
    int   v;
    int   en;
    int   fc;
    logic ce;
    logic pa;
  } model_t;

  model_t m [3];

  function automatic model_t step(model_t s, int i, logic en_in, logic pal_in);
    model_t n = s;
    if (s.ce) begin
      n.h = s.h + 1;
      if (n.h == c_ht[i]) begin
        n.h = 0;
        n.v = s.v + 1;
        if (n.v == (s.pa ? c_vtp[i] : c_vtn[i])) begin
          n.v  = 0;
          n.pa = pal_in;
          n.fc = (s.fc + 1) % 256;
        end
      end
    end
    n.ce = 1'b0;
    if (en_in) begin
      n.en = s.en + 1;
      n.ce = ((n.en % c_div[i]) == 0);
    end
    return n;
  endfunction

  function automatic logic [37:0] exp_vec(model_t s, int i);
    logic hbv, vbv, hsv, vsv, dev, lsv, fsv;
    int va, hsb, vsb;
    hbv = (s.h >= c_ha[i]);
    va  = s.pa ? c_vap[i] : c_van[i];
    vbv = (s.v >= va);
    hsb = c_ha[i] + c_hfp[i];
    vsb = va + c_vfp[i];
    hsv = ((s.h >= hsb) && (s.h < hsb + c_hsy[i])) ? (c_hpl[i] != 0) : (c_hpl[i] == 0);
    vsv = ((s.v >= vsb) && (s.v < vsb + c_vsy[i])) ? (c_vpl[i] != 0) : (c_vpl[i] == 0);
    dev = !(hbv || vbv);
    lsv = s.ce && (s.h == 0);
    fsv = lsv && (s.v == 0);
    return {s.ce, hbv, vbv, hsv, vsv, dev, lsv, fsv, s.pa, 8'(s.fc), 11'(s.h), 10'(s.v)};
  endfunction

  // model state follows the same clock/reset as the instances
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) m[i] <= '0;
      else       m[i] <= step(m[i], i, enable, pal);
    end
  end

  // ------------------------------------------------------------------
  // Checking helpers (all counting happens in the single initial process)
  // ------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic compare_all();
    logic [37:0] act, req;
    for (int i = 0; i < 3; i++) begin
      act = {ce[i], hb[i], vb[i], hs[i], vs[i], de[i], ls[i], fs[i], pa[i], fc[i], hc[i], vc[i]};
      req = exp_vec(m[i], i);
      checks++;
      if (act !== req) begin
        errors++;
        if (errors <= 20)
          $display("FAIL model dut%0d cyc %0d: got %h, expected %h", i, cyc, act, req);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic goto_pos(string name, int d, int h, int v, int limit);
    bit found = 1'b0;
    for (int k = 0; k < limit && !found; k++) begin
      tick();
      if (ce[d] && hc[d] == h && vc[d] == v) found = 1'b1;
    end
    chk({name, " reached"}, int'(found), 1);
  endtask

  task automatic ce_latency(string name, int d, int req);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ce[d] && n < 10);
    chk(name, n, req);
  endtask

  // ------------------------------------------------------------------
  // Directed sequence
  // ------------------------------------------------------------------
  initial begin
    int c0, hold0, cnt;

    repeat (3) tick();
    chk("rst hcount", int'(hc[0]), 0);
    chk("rst vcount", int'(vc[0]), 0);
    chk("rst ce_pix", int'(ce[0]), 0);
    chk("rst de", int'(de[0]), 1);
    chk("rst hsync lowpol", int'(hs[0]), 1);
    chk("rst vsync lowpol", int'(vs[0]), 1);
    chk("rst hsync highpol", int'(hs[2]), 0);
    chk("rst vsync highpol", int'(vs[2]), 0);

    // first ce after release carries frame_start
    reset = 1'b0;
    ce_latency("first ce latency", 0, 2);
    chk("first frame_start", int'(fs[0]), 1);
    chk("first ce hcount", int'(hc[0]), 0);
    c0 = cyc;

    // default line geometry
    goto_pos("h639", 0, 639, 0, 4000);  chk("hblank@639", int'(hb[0]), 0);
    goto_pos("h640", 0, 640, 0, 100);   chk("hblank@640", int'(hb[0]), 1);
    goto_pos("h655", 0, 655, 0, 100);   chk("hsync@655", int'(hs[0]), 1);
    goto_pos("h656", 0, 656, 0, 100);   chk("hsync@656", int'(hs[0]), 0);
    goto_pos("h719", 0, 719, 0, 200);   chk("hsync@719", int'(hs[0]), 0);
    goto_pos("h720", 0, 720, 0, 100);   chk("hsync@720", int'(hs[0]), 1);
    goto_pos("line1", 0, 0, 1, 400);
    chk("line period clk", cyc - c0, 1600);
    chk("line_start line1", int'(ls[0]), 1);
    chk("frame_start line1", int'(fs[0]), 0);

    // small NTSC frame, then a mid-frame PAL request
    goto_pos("d1 frame a", 1, 0, 0, 2000); c0 = cyc;
    goto_pos("d1 frame b", 1, 0, 0, 2000);
    chk("ntsc frame period clk", cyc - c0, 768);
    goto_pos("d1 v5", 1, 0, 5, 1000);
    pal = 1'b1;
    goto_pos("d1 h15", 1, 15, 5, 100);  chk("de@h15", int'(de[1]), 1);
    goto_pos("d1 h16", 1, 16, 5, 100);  chk("de@h16", int'(de[1]), 0);
    goto_pos("d1 v9", 1, 0, 9, 1000);   chk("vblank@9", int'(vb[1]), 0);
    chk("pal ignored midframe", int'(pa[1]), 0);
    goto_pos("d1 v10", 1, 0, 10, 100);  chk("vblank@10", int'(vb[1]), 1);
    chk("vsync ntsc@10", int'(vs[1]), 1);
    goto_pos("d1 v11", 1, 0, 11, 100);  chk("vsync ntsc@11", int'(vs[1]), 0);
    goto_pos("d1 v12", 1, 0, 12, 100);  chk("vsync ntsc@12", int'(vs[1]), 0);
    goto_pos("d1 v13", 1, 0, 13, 100);  chk("vsync ntsc@13", int'(vs[1]), 1);
    goto_pos("d1 last", 1, 23, 15, 200); chk("pal_active last px", int'(pa[1]), 0);
    goto_pos("d1 pal frame", 1, 0, 0, 10);
    chk("pal_active new frame", int'(pa[1]), 1);
    chk("frame_start pal", int'(fs[1]), 1);
    c0 = cyc;
    goto_pos("p v12", 1, 0, 12, 1000);  chk("vblank pal@12", int'(vb[1]), 1);
    chk("vsync pal@12", int'(vs[1]), 1);
    goto_pos("p v13", 1, 0, 13, 100);   chk("vsync pal@13", int'(vs[1]), 0);
    goto_pos("p v14", 1, 0, 14, 100);   chk("vsync pal@14", int'(vs[1]), 0);
    goto_pos("p v15", 1, 0, 15, 100);   chk("vsync pal@15", int'(vs[1]), 1);
    goto_pos("p v19", 1, 0, 19, 300);
    goto_pos("p wrap", 1, 0, 0, 100);
    chk("pal frame period clk", cyc - c0, 960);

    // freeze right after a ce cycle, then resume
    goto_pos("freeze pt", 1, 7, 2, 1000);
    enable = 1'b0;
    cnt = 0;
    tick();
    hold0 = int'(hc[0]);
    for (int k = 0; k < 49; k++) begin
      tick();
      cnt += int'(ce[0]) + int'(ce[1]) + int'(ce[2]);
    end
    chk("ce while frozen", cnt, 0);
    chk("frozen hcount d1", int'(hc[1]), 8);
    chk("frozen hcount d0", int'(hc[0]), hold0);
    enable = 1'b1;
    ce_latency("resume ce latency", 1, 2);
    chk("resume hcount", int'(hc[1]), 8);

    // asynchronous reset in mid-frame
    goto_pos("reset pt", 1, 10, 8, 2000);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async rst hcount", int'(hc[1]), 0);
    chk("async rst vcount", int'(vc[1]), 0);
    chk("async rst ce", int'(ce[1]), 0);
    chk("async rst hblank", int'(hb[1]), 0);
    chk("async rst de", int'(de[1]), 1);
    chk("async rst pal_active", int'(pa[1]), 0);
    chk("async rst frame_cnt", int'(fc[1]), 0);
    chk("async rst hsync", int'(hs[1]), 1);
    chk("async rst pulses", int'(ls[1]) + int'(fs[1]), 0);
    repeat (3) tick();
    reset = 1'b0;
    ce_latency("post rst ce latency", 1, 2);
    chk("post rst frame_start", int'(fs[1]), 1);

    // CE_DIV=1, active-high syncs
    pal = 1'b0;
    repeat (200) tick();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt += int'(ce[2]);
    end
    chk("ce constant high", cnt, 20);
    goto_pos("d2 h4", 2, 4, 0, 200);  chk("hsync hp@4", int'(hs[2]), 0);
    goto_pos("d2 h5", 2, 5, 0, 10);   chk("hsync hp@5", int'(hs[2]), 1);
    goto_pos("d2 h6", 2, 6, 0, 10);   chk("hsync hp@6", int'(hs[2]), 0);
    chk("d2 ntsc mode", int'(pa[2]), 0);
    goto_pos("d2 v3", 2, 0, 3, 100);  chk("vsync hp@3", int'(vs[2]), 0);
    goto_pos("d2 v4", 2, 0, 4, 100);  chk("vsync hp@4", int'(vs[2]), 1);
    goto_pos("d2 v5", 2, 0, 5, 100);  chk("vsync hp@5", int'(vs[2]), 0);

    // frame counter wrap 255 -> 0
    cnt = 0;
    while (fc[2] != 8'd255 && cnt < 20000) begin
      tick();
      cnt++;
    end
    chk("frame_cnt reaches 255", int'(fc[2]), 255);
    goto_pos("d2 wrap", 2, 0, 0, 100);
    chk("frame_cnt wraps", int'(fc[2]), 0);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
